// File: rtl/cpu_pkg.sv
// Types and constants shared by the boot loader, the cpu core and the instruction memory.
package cpu_pkg;

  typedef logic [31:0] word_t;

  localparam int WORD_BYTES = 4;
  localparam int LEN_BYTES  = 2;

  typedef enum logic [2:0] {
    S_LEN0 = 3'd0,
    S_LEN1 = 3'd1,
    S_DATA = 3'd2,
    S_CSUM = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } loader_state_t;

endpackage

// File: rtl/prog_loader_byte_packer.sv
// Collects stream bytes little-endian into a 32-bit word and pulses word_valid
// for one cycle after the fourth byte of each word has been taken.
module byte_packer
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  output logic       word_valid,
  output word_t      word,
  output logic [1:0] byte_idx
);

  word_t word_q;

  // The pulse lands in the cycle where word_q already holds all four lanes;
  // lane 0 of the next word is only overwritten at the end of that cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_idx   <= 2'd0;
      word_q     <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (byte_valid) begin
        word_q[{byte_idx, 3'b000} +: 8] <= byte_data;
        byte_idx                        <= byte_idx + 2'd1;
        if (byte_idx == 2'(WORD_BYTES - 1)) begin
          word_valid <= 1'b1;
        end
      end
    end
  end

  assign word = word_q;

endmodule

// File: rtl/prog_loader.sv
// Boot loader: parses LEN_LO, LEN_HI, data bytes and an XOR checksum from a byte
// stream, writes packed words to imem and releases the cpu only on a verified image.
module prog_loader
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [15:0]       word_count
);

  localparam logic [16:0] DEPTH_LIM = 17'(DEPTH);

  loader_state_t state;
  loader_state_t state_nx;
  logic [15:0]   len_q;
  logic [15:0]   len_in;
  logic [7:0]    csum;
  logic [1:0]    byte_idx;
  logic          accept;
  logic          data_take;
  logic          last_word;

  // Handshake: a byte moves when in_valid && in_ready at a rising edge; in_data
  // is ignored otherwise. in_ready is forced low while reset is asserted.
  assign in_ready = rst & ((state == S_LEN0) || (state == S_LEN1) ||
                           (state == S_DATA) || (state == S_CSUM));
  assign accept    = in_valid & in_ready;
  assign data_take = accept & (state == S_DATA);
  assign len_in    = {in_data, len_q[7:0]};

  // The previous word's write has always retired by the 4th byte of the next
  // word, so word_count counts every completed word at this point.
  assign last_word = (byte_idx == 2'(WORD_BYTES - 1)) &&
                     ((word_count + 16'd1) == len_q);

  byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .byte_valid (data_take),
    .byte_data  (in_data),
    .word_valid (imem_we),
    .word       (imem_wdata),
    .byte_idx   (byte_idx)
  );

  always_comb begin
    state_nx = state;
    if (accept) begin
      case (state)
        S_LEN0: state_nx = S_LEN1;
        S_LEN1: begin
          if ({1'b0, len_in} > DEPTH_LIM) begin
            state_nx = S_ERR;
          end else if (len_in == 16'd0) begin
            state_nx = S_CSUM;
          end else begin
            state_nx = S_DATA;
          end
        end
        S_DATA: if (last_word) state_nx = S_CSUM;
        S_CSUM: state_nx = (in_data == csum) ? S_DONE : S_ERR;
        default: state_nx = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_LEN0;
      len_q      <= 16'd0;
      csum       <= 8'd0;
      word_count <= 16'd0;
    end else begin
      state <= state_nx;
      if (accept && (state == S_LEN0)) len_q[7:0]  <= in_data;
      if (accept && (state == S_LEN1)) len_q[15:8] <= in_data;
      if (data_take) csum <= csum ^ in_data;
      if (imem_we) word_count <= word_count + 16'd1;
    end
  end

  assign imem_addr = word_count[ADDR_W-1:0];
  assign done      = (state == S_DONE);
  assign error     = (state == S_ERR);
  assign cpu_hold  = (state != S_DONE);

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: scenario tasks compare the imem write
// sequence and status outputs against an image-level reference model.
module tb_prog_loader;

  localparam int ADDR_W = 8;
  localparam int DEPTH  = 256;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic              in_valid = 1'b0;
  logic [7:0]        in_data  = 8'd0;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_hold;
  logic              done;
  logic              error;
  logic [15:0]       word_count;

  prog_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .error      (error),
    .word_count (word_count)
  );

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [7:0]        data_b[$];
  logic [7:0]        stream_q[$];
  logic [31:0]       exp_q[$];
  bit                exp_done;
  bit                exp_err;
  int                exp_wc;

  // observed imem writes
  logic [31:0]       obs_data_q[$];
  logic [ADDR_W-1:0] obs_addr_q[$];
  int                we_pairs = 0;
  logic              prev_we  = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      prev_we = 1'b0;
    end else begin
      if (imem_we) begin
        obs_data_q.push_back(imem_wdata);
        obs_addr_q.push_back(imem_addr);
        if (prev_we) we_pairs++;
      end
      prev_we = imem_we;
    end
  end

  // Builds the byte stream and expected outcome from the image contents.
  // csum_byte < 0 means "use the correct checksum".
  function automatic void build_load(input int n, input int csum_byte);
    logic [7:0] c;
    logic [7:0] sent;
    c = 8'd0;
    stream_q.delete();
    exp_q.delete();
    stream_q.push_back(8'(n % 256));
    stream_q.push_back(8'(n / 256));
    foreach (data_b[i]) begin
      stream_q.push_back(data_b[i]);
      c = c ^ data_b[i];
    end
    sent = (csum_byte < 0) ? c : 8'(csum_byte);
    stream_q.push_back(sent);
    if (n > DEPTH) begin
      exp_err  = 1'b1;
      exp_done = 1'b0;
      exp_wc   = 0;
    end else begin
      exp_err  = (sent != c);
      exp_done = !exp_err;
      exp_wc   = n;
      for (int w = 0; w < n; w++) begin
        exp_q.push_back(32'(data_b[4*w]) + 32'(data_b[4*w+1]) * 256 +
                        32'(data_b[4*w+2]) * 65536 + 32'(data_b[4*w+3]) * 16777216);
      end
    end
  endfunction

  function automatic void nominal_data();
    data_b = '{8'h13, 8'h01, 8'h10, 8'h00, 8'h93, 8'h01, 8'h20, 8'h00};
  endfunction

  function automatic void random_data(input int n);
    data_b.delete();
    for (int i = 0; i < 4 * n; i++) data_b.push_back(8'($urandom));
  endfunction

  // driver tasks
  task automatic do_reset();
    in_valid = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    obs_data_q.delete();
    obs_addr_q.delete();
    we_pairs = 0;
  endtask

  task automatic drive_stream(input int gap, input int limit);
    for (int i = 0; i < limit && i < stream_q.size(); i++) begin
      @(negedge clk);
      if (!in_ready) begin
        in_valid = 1'b0;
        break;
      end
      in_valid = 1'b1;
      in_data  = stream_q[i];
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'($urandom);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  // scenarios
  task automatic test_reset();
    rst = 1'b0;
    in_valid = 1'b1;
    in_data = 8'hA5;
    repeat (3) @(negedge clk);
    checks++;
    if ({in_ready, cpu_hold, imem_we, done, error} !== 5'b01000) begin
      errors++;
      $display("FAIL reset_flags: ready/hold/we/done/err got %b want 01000",
               {in_ready, cpu_hold, imem_we, done, error});
    end
    checks++;
    if ({imem_addr, imem_wdata, word_count} !== '0) begin
      errors++;
      $display("FAIL reset_values: addr %0h wdata %0h wc %0d want all zero",
               imem_addr, imem_wdata, word_count);
    end
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset: got %b want 1", in_ready);
    end
  endtask

  task automatic test_nominal();
    do_reset();
    nominal_data();
    build_load(2, -1);
    drive_stream(0, stream_q.size());
    checks++;
    if ({done, error, cpu_hold, in_ready} !== 4'b1000) begin
      errors++;
      $display("FAIL nominal_status: done/err/hold/ready got %b want 1000",
               {done, error, cpu_hold, in_ready});
    end
    repeat (2) @(negedge clk);
    checks++;
    if (obs_data_q.size() != exp_q.size() || we_pairs != 0) begin
      errors++;
      $display("FAIL nominal_writes: count %0d pairs %0d want %0d pairs 0",
               obs_data_q.size(), we_pairs, exp_q.size());
    end
    foreach (exp_q[i]) begin
      if (i < obs_data_q.size()) begin
        checks++;
        if (obs_data_q[i] !== exp_q[i] || obs_addr_q[i] !== ADDR_W'(i)) begin
          errors++;
          $display("FAIL nominal_word%0d: addr %0d data %08h want addr %0d data %08h",
                   i, obs_addr_q[i], obs_data_q[i], i, exp_q[i]);
        end
      end
    end
    checks++;
    if (word_count !== 16'(exp_wc)) begin
      errors++;
      $display("FAIL nominal_wc: got %0d want %0d", word_count, exp_wc);
    end
  endtask

  task automatic test_bad_csum();
    do_reset();
    nominal_data();
    build_load(2, 0);
    drive_stream(0, stream_q.size());
    repeat (2) @(negedge clk);
    checks++;
    if ({done, error, cpu_hold, in_ready} !== 4'b0110 || !exp_err) begin
      errors++;
      $display("FAIL badcsum_status: done/err/hold/ready got %b want 0110",
               {done, error, cpu_hold, in_ready});
    end
    checks++;
    if (obs_data_q.size() != 2 || obs_data_q[0] !== exp_q[0] || obs_data_q[1] !== exp_q[1]) begin
      errors++;
      $display("FAIL badcsum_writes: count %0d want 2 words %08h %08h",
               obs_data_q.size(), exp_q[0], exp_q[1]);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    random_data(4);
    build_load(257, -1);
    drive_stream(0, 2);
    checks++;
    if ({done, error, cpu_hold, in_ready} !== 4'b0110) begin
      errors++;
      $display("FAIL overflow_status: done/err/hold/ready got %b want 0110",
               {done, error, cpu_hold, in_ready});
    end
    drive_stream(0, stream_q.size());
    checks++;
    if (obs_data_q.size() != 0 || word_count !== 16'd0 || error !== 1'b1) begin
      errors++;
      $display("FAIL overflow_writes: writes %0d wc %0d err %b want 0 0 1",
               obs_data_q.size(), word_count, error);
    end
  endtask

  task automatic test_zero_len();
    do_reset();
    data_b.delete();
    build_load(0, -1);
    drive_stream(0, stream_q.size());
    checks++;
    if ({done, error, cpu_hold} !== 3'b100 || word_count !== 16'd0 || obs_data_q.size() != 0) begin
      errors++;
      $display("FAIL zero_len: done/err/hold %b wc %0d writes %0d want 100 0 0",
               {done, error, cpu_hold}, word_count, obs_data_q.size());
    end
  endtask

  task automatic test_throttle();
    do_reset();
    nominal_data();
    build_load(2, -1);
    drive_stream(3, stream_q.size());
    repeat (2) @(negedge clk);
    checks++;
    if (done !== 1'b1 || error !== 1'b0 || obs_data_q.size() != 2) begin
      errors++;
      $display("FAIL throttle_status: done %b err %b writes %0d want 1 0 2",
               done, error, obs_data_q.size());
    end
    foreach (exp_q[i]) begin
      if (i < obs_data_q.size()) begin
        checks++;
        if (obs_data_q[i] !== exp_q[i] || obs_addr_q[i] !== ADDR_W'(i)) begin
          errors++;
          $display("FAIL throttle_word%0d: addr %0d data %08h want addr %0d data %08h",
                   i, obs_addr_q[i], obs_data_q[i], i, exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_load();
    do_reset();
    nominal_data();
    build_load(2, -1);
    drive_stream(0, 7);
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({in_ready, cpu_hold, imem_we, done, error} !== 5'b01000 ||
        word_count !== 16'd0 || imem_addr !== '0 || imem_wdata !== 32'd0) begin
      errors++;
      $display("FAIL midreset_async: flags %b wc %0d addr %0d wdata %08h want 01000 0 0 0",
               {in_ready, cpu_hold, imem_we, done, error}, word_count, imem_addr, imem_wdata);
    end
    @(negedge clk);
    rst = 1'b1;
    obs_data_q.delete();
    obs_addr_q.delete();
    drive_stream(0, stream_q.size());
    repeat (2) @(negedge clk);
    checks++;
    if (done !== 1'b1 || obs_data_q.size() != 2) begin
      errors++;
      $display("FAIL midreset_replay: done %b writes %0d want 1 2", done, obs_data_q.size());
    end
    foreach (exp_q[i]) begin
      if (i < obs_data_q.size()) begin
        checks++;
        if (obs_data_q[i] !== exp_q[i] || obs_addr_q[i] !== ADDR_W'(i)) begin
          errors++;
          $display("FAIL midreset_word%0d: addr %0d data %08h want addr %0d data %08h",
                   i, obs_addr_q[i], obs_data_q[i], i, exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_full_depth();
    int bad;
    do_reset();
    random_data(DEPTH);
    build_load(DEPTH, -1);
    drive_stream(0, stream_q.size());
    repeat (2) @(negedge clk);
    bad = 0;
    foreach (exp_q[i]) begin
      if (i >= obs_data_q.size() || obs_data_q[i] !== exp_q[i] || obs_addr_q[i] !== ADDR_W'(i)) bad++;
    end
    checks++;
    if (bad != 0 || obs_data_q.size() != DEPTH || done !== 1'b1 ||
        word_count !== 16'(DEPTH) || we_pairs != 0) begin
      errors++;
      $display("FAIL full_depth: bad words %0d writes %0d done %b wc %0d pairs %0d want 0 %0d 1 %0d 0",
               bad, obs_data_q.size(), done, word_count, we_pairs, DEPTH, DEPTH);
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 6; t++) begin
      int n;
      int gap;
      int bad;
      n   = $urandom_range(1, 9);
      gap = $urandom_range(0, 2);
      do_reset();
      random_data(n);
      build_load(n, ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 255)) : -1);
      drive_stream(gap, stream_q.size());
      repeat (2) @(negedge clk);
      bad = 0;
      foreach (exp_q[i]) begin
        if (i >= obs_data_q.size() || obs_data_q[i] !== exp_q[i] || obs_addr_q[i] !== ADDR_W'(i)) bad++;
      end
      checks++;
      if (bad != 0 || obs_data_q.size() != exp_q.size() || we_pairs != 0) begin
        errors++;
        $display("FAIL random%0d_writes: bad %0d writes %0d pairs %0d want 0 %0d 0",
                 t, bad, obs_data_q.size(), we_pairs, exp_q.size());
      end
      checks++;
      if (done !== exp_done || error !== exp_err || cpu_hold !== !exp_done ||
          word_count !== 16'(exp_wc) || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL random%0d_status: done %b err %b hold %b wc %0d ready %b want %b %b %b %0d 0",
                 t, done, error, cpu_hold, word_count, in_ready,
                 exp_done, exp_err, !exp_done, exp_wc);
      end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_bad_csum();
    test_overflow();
    test_zero_len();
    test_throttle();
    test_reset_mid_load();
    test_full_depth();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
